ledcube_frame_scheduler: RTL and testbench

Frame-level controller for the WS2812B LED cube chain. It owns a double-buffered frame RAM of two 512-pixel banks. Host pixel writes go to the back bank, and it triggers one driver frame per refresh period from the front bank. On host request it swaps banks only at a frame boundary. It sits between the host/pattern generator, the frame block RAM write port and the `ws2812b_driver` read side.

---
 rtl/ledcube_frame_scheduler_if.sv | 33 +++
 rtl/ledcube_frame_scheduler.sv | 133 +++++++++++++
 tb/tb_ledcube_frame_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ledcube_frame_scheduler_if.sv
// Host, frame-RAM and driver signals of the LED cube frame scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface ledcube_frame_scheduler_if;
    logic        EN;
    logic        HOST_WE;
    logic [9:0]  HOST_ADDR;
    logic [23:0] HOST_DATA;
    logic        HOST_SWAP_REQ;
    logic        HOST_READY;
    logic        HOST_SWAP_ACK;
    logic        WR_EN;
    logic [10:0] WR_ADDR;
    logic [23:0] WR_DATA;
    logic [9:0]  DRV_ADDR;
    logic [10:0] RD_ADDR;
    logic        DRV_START;
    logic        DRV_DONE;
    logic        FRONT_BANK;
    logic [15:0] FRAME_COUNT;
    logic        OVERRUN;

    modport slave (
        input  EN, HOST_WE, HOST_ADDR, HOST_DATA, HOST_SWAP_REQ, DRV_ADDR, DRV_DONE,
        output HOST_READY, HOST_SWAP_ACK, WR_EN, WR_ADDR, WR_DATA, RD_ADDR,
               DRV_START, FRONT_BANK, FRAME_COUNT, OVERRUN
    );

    modport master (
        output EN, HOST_WE, HOST_ADDR, HOST_DATA, HOST_SWAP_REQ, DRV_ADDR, DRV_DONE,
        input  HOST_READY, HOST_SWAP_ACK, WR_EN, WR_ADDR, WR_DATA, RD_ADDR,
               DRV_START, FRONT_BANK, FRAME_COUNT, OVERRUN
    );
endinterface

// File: rtl/ledcube_frame_scheduler.sv
// Frame scheduler for the WS2812B LED cube: double-buffered frame RAM banks,
// one driver frame per refresh tick, bank swaps only at frame boundaries.
module ledcube_frame_scheduler #(
    parameter int PIXELS       = 512,
    parameter int FRAME_PERIOD = 333333
) (
    input  logic                     CLK,
    input  logic                     RESET,
    ledcube_frame_scheduler_if.slave bus
);
    localparam int            TW        = $clog2(FRAME_PERIOD);
    localparam logic [TW-1:0] T_LAST    = TW'(FRAME_PERIOD - 1);
    localparam logic [10:0]   PIX_LIMIT = 11'(PIXELS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        SWAP      = 3'd2,
        START     = 3'd3,
        SENDING   = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [TW-1:0] timer_r;
    logic          tick_pending_r, swap_pending_r, overrun_r;
    logic          front_bank_r, ack_r, drv_start_r;
    logic [15:0]   frame_count_r;
    logic          wr_en_r;
    logic [10:0]   wr_addr_r;
    logic [23:0]   wr_data_r;
    logic          wrap_s, in_frame_s, frame_done_s, write_ok_s;

    assign wrap_s       = (state_r != IDLE) && (timer_r == T_LAST);
    assign in_frame_s   = (state_r == SWAP) || (state_r == START) || (state_r == SENDING);
    assign frame_done_s = (state_r == SENDING) && bus.DRV_DONE;
    // Writes are blocked for the whole pending/SWAP window so the front bank is never touched.
    assign write_ok_s   = bus.HOST_WE && !swap_pending_r && ({1'b0, bus.HOST_ADDR} < PIX_LIMIT);

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.EN) state_s = WAIT_TICK;
                else        state_s = IDLE;
            end
            WAIT_TICK: begin
                if (tick_pending_r && swap_pending_r) state_s = SWAP;
                else if (tick_pending_r)              state_s = START;
                else if (!bus.EN)                     state_s = IDLE;
                else                                  state_s = WAIT_TICK;
            end
            SWAP:    state_s = START;
            START:   state_s = SENDING;
            SENDING: begin
                if (bus.DRV_DONE && bus.EN) state_s = WAIT_TICK;
                else if (bus.DRV_DONE)      state_s = IDLE;
                else                        state_s = SENDING;
            end
            default: state_s = IDLE;
        endcase
    end

    // Refresh timer plus tick, swap-request and overrun flags.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            timer_r        <= {TW{1'b0}};
            tick_pending_r <= 1'b0;
            swap_pending_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            if (state_r == IDLE) begin
                timer_r        <= {TW{1'b0}};
                tick_pending_r <= 1'b0;
            end else begin
                timer_r <= wrap_s ? {TW{1'b0}} : timer_r + TW'(1);
                // A wrap landing in START keeps the tick: it belongs to the next frame.
                if (wrap_s)                 tick_pending_r <= 1'b1;
                else if (state_r == START)  tick_pending_r <= 1'b0;
            end
            if (wrap_s && in_frame_s) overrun_r <= 1'b1;
            if (bus.HOST_SWAP_REQ)      swap_pending_r <= 1'b1;
            else if (state_r == SWAP)   swap_pending_r <= 1'b0;
        end
    end

    // Registered frame-control outputs, decoded from the upcoming state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ack_r         <= 1'b0;
            drv_start_r   <= 1'b0;
            front_bank_r  <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            ack_r       <= (state_s == SWAP);
            drv_start_r <= (state_s == START);
            if (state_s == SWAP) front_bank_r  <= ~front_bank_r;
            if (frame_done_s)    frame_count_r <= frame_count_r + 16'd1;
        end
    end

    // Host write path into the back bank.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 11'd0;
            wr_data_r <= 24'd0;
        end else begin
            wr_en_r <= write_ok_s;
            if (write_ok_s) begin
                wr_addr_r <= {~front_bank_r, bus.HOST_ADDR};
                wr_data_r <= bus.HOST_DATA;
            end
        end
    end

    assign bus.HOST_READY    = ~swap_pending_r;
    assign bus.HOST_SWAP_ACK = ack_r;
    assign bus.WR_EN         = wr_en_r;
    assign bus.WR_ADDR       = wr_addr_r;
    assign bus.WR_DATA       = wr_data_r;
    assign bus.RD_ADDR       = {front_bank_r, bus.DRV_ADDR};
    assign bus.DRV_START     = drv_start_r;
    assign bus.FRONT_BANK    = front_bank_r;
    assign bus.FRAME_COUNT   = frame_count_r;
    assign bus.OVERRUN       = overrun_r;
endmodule

// File: tb/tb_ledcube_frame_scheduler.sv
// Directed bench for ledcube_frame_scheduler with a behavioural driver model and
// scoreboard queues for expected DRV_START cycles, swap acks and RAM writes.
module tb_ledcube_frame_scheduler;
    logic CLK = 1'b0;
    logic RESET;
    ledcube_frame_scheduler_if bus ();

    ledcube_frame_scheduler #(.PIXELS(512), .FRAME_PERIOD(20)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          cnt = 0;
    int          drv_delay = 10;
    int          exp_count = 0;
    int          c0, c1;
    int          start_q[$];
    int          ack_q[$];
    logic [34:0] wr_q[$];

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, run the driver model, pop the scoreboards.
    task automatic step();
        int          e;
        logic [34:0] w;
        @(posedge CLK);
        cyc++;
        #1;
        if (bus.DRV_DONE) begin
            exp_count++;
            bus.DRV_DONE = 1'b0;
            check("frame_count", 36'(bus.FRAME_COUNT), 36'(exp_count));
        end
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) bus.DRV_DONE = 1'b1;
        end
        if (bus.DRV_START) begin
            cnt = drv_delay;
            if (start_q.size() == 0) check("start_unexpected", 36'(bus.DRV_START), 36'd0);
            else begin
                e = start_q.pop_front();
                check("start_cycle", 36'(cyc), 36'(e));
            end
        end
        if (bus.HOST_SWAP_ACK) begin
            if (ack_q.size() == 0) check("ack_unexpected", 36'(bus.HOST_SWAP_ACK), 36'd0);
            else begin
                e = ack_q.pop_front();
                check("ack_cycle", 36'(cyc), 36'(e));
            end
        end
        if (bus.WR_EN) begin
            if (wr_q.size() == 0) check("wr_unexpected", 36'(bus.WR_EN), 36'd0);
            else begin
                w = wr_q.pop_front();
                check("wr_addr_data", {1'b0, bus.WR_ADDR, bus.WR_DATA}, {1'b0, w});
            end
        end
    endtask

    initial begin
        RESET             = 1'b0;
        bus.EN            = 1'b0;
        bus.HOST_WE       = 1'b0;
        bus.HOST_ADDR     = 10'd0;
        bus.HOST_DATA     = 24'd0;
        bus.HOST_SWAP_REQ = 1'b0;
        bus.DRV_ADDR      = 10'd0;
        bus.DRV_DONE      = 1'b0;
        repeat (2) step();
        check("rst_ready",   36'(bus.HOST_READY),    36'd1);
        check("rst_ack",     36'(bus.HOST_SWAP_ACK), 36'd0);
        check("rst_wr_en",   36'(bus.WR_EN),         36'd0);
        check("rst_wr_addr", 36'(bus.WR_ADDR),       36'd0);
        check("rst_wr_data", 36'(bus.WR_DATA),       36'd0);
        check("rst_start",   36'(bus.DRV_START),     36'd0);
        check("rst_front",   36'(bus.FRONT_BANK),    36'd0);
        check("rst_count",   36'(bus.FRAME_COUNT),   36'd0);
        check("rst_overrun", 36'(bus.OVERRUN),       36'd0);
        RESET = 1'b1;
        step();

        // Write path while idle; the back bank (1) lands in address bit 10.
        bus.HOST_WE = 1'b1; bus.HOST_ADDR = 10'd5; bus.HOST_DATA = 24'h123456;
        wr_q.push_back({11'h405, 24'h123456});
        step();
        check("wr_latency", 36'(bus.WR_EN), 36'd1);
        bus.HOST_ADDR = 10'd600; bus.HOST_DATA = 24'h654321;
        step();
        check("wr_drop_range", 36'(bus.WR_EN), 36'd0);
        bus.HOST_ADDR = 10'd511; bus.HOST_DATA = 24'hA5A5A5;
        wr_q.push_back({11'h5FF, 24'hA5A5A5});
        step();
        bus.HOST_WE = 1'b0;
        step();

        // Steady refresh: first start 22 cycles after EN, then every 20.
        c0 = cyc;
        bus.EN = 1'b1;
        start_q.push_back(c0 + 22); start_q.push_back(c0 + 42);
        start_q.push_back(c0 + 62); start_q.push_back(c0 + 82);
        while (cyc < c0 + 90) step();
        check("steady_overrun", 36'(bus.OVERRUN),    36'd0);
        check("steady_front",   36'(bus.FRONT_BANK), 36'd0);

        // Swap request mid-frame: ack on the cycle before the next DRV_START.
        bus.HOST_SWAP_REQ = 1'b1;
        ack_q.push_back(c0 + 102);
        start_q.push_back(c0 + 103);
        step();
        bus.HOST_SWAP_REQ = 1'b0;
        check("ready_low", 36'(bus.HOST_READY), 36'd0);
        bus.HOST_WE = 1'b1; bus.HOST_ADDR = 10'd7; bus.HOST_DATA = 24'h777777;
        step();
        bus.HOST_WE = 1'b0;
        check("ready_low", 36'(bus.HOST_READY), 36'd0);
        while (cyc < c0 + 102) begin
            step();
            check("ready_low", 36'(bus.HOST_READY), 36'd0);
        end
        step();
        check("ready_after_swap", 36'(bus.HOST_READY), 36'd1);
        check("front_after_swap", 36'(bus.FRONT_BANK), 36'd1);
        bus.DRV_ADDR = 10'h02A;
        #1;
        check("rd_addr", 36'(bus.RD_ADDR), 36'h42A);
        bus.HOST_WE = 1'b1; bus.HOST_ADDR = 10'd9; bus.HOST_DATA = 24'hABCDEF;
        wr_q.push_back({11'h009, 24'hABCDEF});
        step();
        bus.HOST_WE = 1'b0;

        // Overrun: a 30-cycle frame straddles the wrap at c0+140.
        drv_delay = 30;
        start_q.push_back(c0 + 122);
        while (cyc < c0 + 130) step();
        check("overrun_clear", 36'(bus.OVERRUN), 36'd0);
        start_q.push_back(c0 + 154);
        while (cyc < c0 + 150) step();
        check("overrun_set", 36'(bus.OVERRUN), 36'd1);
        drv_delay = 10;

        // EN drop during SENDING: frame completes, then no further starts.
        while (cyc < c0 + 156) step();
        bus.EN = 1'b0;
        while (cyc < c0 + 200) step();
        check("en_drop_count",   36'(bus.FRAME_COUNT), 36'd7);
        check("overrun_sticky",  36'(bus.OVERRUN),     36'd1);

        // Async reset in the middle of a frame, between clock edges.
        bus.EN = 1'b1;
        start_q.push_back(c0 + 222);
        while (cyc < c0 + 226) step();
        check("pre_rst_front", 36'(bus.FRONT_BANK),  36'd1);
        check("pre_rst_count", 36'(bus.FRAME_COUNT), 36'd7);
        #2;
        RESET = 1'b0;
        #1;
        check("async_front",   36'(bus.FRONT_BANK),  36'd0);
        check("async_count",   36'(bus.FRAME_COUNT), 36'd0);
        check("async_overrun", 36'(bus.OVERRUN),     36'd0);
        check("async_ready",   36'(bus.HOST_READY),  36'd1);
        check("async_wr_addr", 36'(bus.WR_ADDR),     36'd0);
        check("async_wr_data", 36'(bus.WR_DATA),     36'd0);
        bus.DRV_DONE = 1'b0;
        cnt          = 0;
        exp_count    = 0;
        repeat (3) step();
        c1 = cyc;
        RESET = 1'b1;
        start_q.push_back(c1 + 22);
        while (cyc < c1 + 36) step();

        check("start_q_drained", 36'(start_q.size()), 36'd0);
        check("ack_q_drained",   36'(ack_q.size()),   36'd0);
        check("wr_q_drained",    36'(wr_q.size()),    36'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
